// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory loader.
// FSM encoding, header length and word-address width.
package imem_pkg;

  localparam int HDR_BYTES = 4;
  localparam int WADDR_W   = 30;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
    WRITE    = 3'd4,
    CSUM     = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in [31:24].
// The word is presented combinationally with the 4th byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  // shift accepted bytes in, count modulo 4
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (push) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;
    end
  end

  assign word = {sr, din};
  assign last = push && (cnt == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Serial-to-IMEM loader: header (addr, count), data words, checksum.
// Define IMEM_LOADER_CSUM_EN to check a trailing 8-bit byte sum.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MAX_WORDS = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WADDR_W-1:0]   imem_addr,
  output logic [31:0]          imem_din,
  output logic [3:0]           imem_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t             state;
  logic [WADDR_W-1:0] base;
  logic [31:0]        n_words;
  logic [31:0]        idx;
  logic               accept;
  logic               idle_like;
  logic               pk_clr;
  logic               pk_last;
  logic [31:0]        pk_word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]         csum;
`endif

  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign pk_clr    = idle_like && start;
  assign accept    = in_valid && in_ready;

  byte_packer u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (pk_clr),
    .push (accept),
    .din  (in_data),
    .word (pk_word),
    .last (pk_last)
  );

  // byte acceptance window; nothing is taken while in reset
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      HDR_ADDR, HDR_CNT, DATA: in_ready = !rst;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:                    in_ready = !rst;
`endif
      default:                 in_ready = 1'b0;
    endcase
  end

  assign imem_we = (state == WRITE && !rst) ? 4'hF : 4'h0;
  assign busy    = !idle_like;
  assign done    = (state == DONE);
  assign err     = (state == ERR);

  // load sequencer; addr/din only change when a word is staged
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      n_words   <= '0;
      idx       <= '0;
      imem_addr <= '0;
      imem_din  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= HDR_ADDR;
            base    <= '0;
            n_words <= '0;
            idx     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum    <= '0;
`endif
          end
        end
        HDR_ADDR: begin
          if (pk_last) begin
            if (pk_word[1:0] != 2'b00) begin
              state <= ERR;
            end else begin
              base  <= pk_word[31:2];
              state <= HDR_CNT;
            end
          end
        end
        HDR_CNT: begin
          if (pk_last) begin
            n_words <= pk_word;
            if (pk_word > MAX_W)
              state <= ERR;
            else if (pk_word == 32'd0)
              state <= CSUM;
            else
              state <= DATA;
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
          if (accept)
            csum <= csum + in_data;
`endif
          if (pk_last) begin
            imem_din  <= pk_word;
            imem_addr <= base + idx[WADDR_W-1:0];
            state     <= WRITE;
          end
        end
        WRITE: begin
          idx <= idx + 32'd1;
          if (idx + 32'd1 == n_words)
            state <= CSUM;
          else
            state <= DATA;
        end
        CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
          if (accept)
            state <= (in_data == csum) ? DONE : ERR;
`else
          state <= DONE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4096, the largest word count accepted in one load.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse that arms a new load.
REQ-005 SHALL have port in_data  input  8  byte from the serial receiver.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port imem_addr  output  30  word address into instruction memory.
REQ-009 SHALL have port imem_din  output  32  instruction word to write.
REQ-010 SHALL have port imem_we  output  4  byte write enables; all ones or all zeros.
REQ-011 SHALL have port busy  output  1  high from start until DONE or ERR.
REQ-012 SHALL have port done  output  1  load completed successfully; held high.
REQ-013 SHALL have port err  output  1  load aborted; held high.

Function
REQ-014 SHALL accept a byte only on a cycle where in_valid and in_ready are both high.
REQ-015 SHALL run an FSM with states IDLE, HDR_ADDR, HDR_CNT, DATA, WRITE, CSUM, DONE and ERR.
REQ-016 SHALL, on start in IDLE, DONE or ERR, clear done, err and counters, and enter HDR_ADDR the next cycle.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL, in HDR_ADDR, take 4 bytes as a big-endian byte address and enter HDR_CNT.
REQ-019 SHALL enter ERR if the low 2 bits of that address are not zero.
REQ-020 SHALL store the base word address as the byte address bits [31:2].
REQ-021 SHALL, in HDR_CNT, take 4 bytes as a big-endian word count N.
REQ-022 SHALL enter ERR when N > MAX_WORDS, enter CSUM when N = 0, and otherwise enter DATA.
REQ-023 SHALL, in DATA, assemble each group of 4 accepted bytes big-endian, with the first byte going to bits [31:24].
REQ-024 SHALL go from DATA to WRITE on the cycle the 4th byte is accepted.
REQ-025 SHALL, in WRITE, drive imem_we=4'hF for exactly one cycle, with imem_din as the assembled word and imem_addr = base + index.
REQ-026 SHALL perform the address addition modulo 2^30, so the address wraps.
REQ-027 SHALL write each word exactly one cycle after its 4th byte is accepted.
REQ-028 SHALL, after the write, increment index and return to DATA, or go to CSUM once index reaches N.
REQ-029 SHALL drive in_ready high only in HDR_ADDR, HDR_CNT, DATA and CSUM.
REQ-030 SHALL hold in_ready low in WRITE, so there is one stall cycle per word.
REQ-031 SHALL hold imem_we at 0 in every state except WRITE.
REQ-032 SHALL keep imem_addr and imem_din stable while imem_we is 0.
REQ-033 SHALL assert busy in every state except IDLE, DONE and ERR.
REQ-034 SHALL hold done and err high until the next start or rst.
REQ-035 SHALL leave any write already performed in place when it enters ERR.

Reset
REQ-036 SHALL, on rst, go to IDLE and set in_ready=0, imem_we=0, imem_addr=0, imem_din=0, busy=0, done=0 and err=0.
REQ-037 SHALL give rst priority over start and over an in-flight load.
REQ-038 SHALL perform no write on a cycle where rst is high, even when that reset arrives in WRITE.

Configuration
REQ-039 SHALL, when IMEM_LOADER_CSUM_EN is defined, keep an 8-bit running sum modulo 256 of all DATA bytes.
REQ-040 SHALL, with IMEM_LOADER_CSUM_EN defined, take one byte in CSUM and enter DONE if it equals the sum, otherwise ERR.
REQ-041 SHALL, with IMEM_LOADER_CSUM_EN undefined, pass from CSUM to DONE on the next cycle, consume no byte, and hold in_ready low in CSUM.

Structure
REQ-042 SHALL take the FSM state enum and the header length constant (4 bytes) from a shared package, imem_pkg.
REQ-043 SHALL keep the existing 30-bit word-address width shared with the instruction ROM.
REQ-044 SHALL implement the big-endian byte-to-word assembly as one sub-module, byte_packer, with a 4-byte shift register and count, also used for the header fields.

Verification
REQ-045 SHALL cover: start; bytes 00 00 00 10, 00 00 00 02, 3C 1D 10 00, 0C 00 03 43 -> writes 3C1D1000 @ 0x4 then 0C000343 @ 0x5, done=1.
REQ-046 SHALL cover: address 00 00 00 06 -> err=1 after the 4th header byte, no write.
REQ-047 SHALL cover: count 00 00 10 01 with MAX_WORDS=4096 -> err=1, no write.
REQ-048 SHALL cover: address 0xFFFFFFFC with N=2 -> writes at 0x3FFFFFFF then 0x00000000.
REQ-049 SHALL cover: rst asserted in WRITE -> imem_we=0 that cycle, IDLE next cycle, all outputs 0.
REQ-050 SHALL cover, with IMEM_LOADER_CSUM_EN defined: data 01 02 03 04 then checksum 0A -> done=1; then checksum 0B -> err=1 with the word already written.
